// File: rtl/dmem_tb_engine.sv
// rtl/dmem_tb_engine.sv - command-driven LOAD/DUMP initiator for the data memory testbench port
module dmem_tb_engine #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW:0]   cmd_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [31:0]   m_data,
  output logic          m_last,
  input  logic          cpu_we,
  output logic          tb_we,
  output logic [AW-1:0] tb_addr,
  output logic [31:0]   tb_wdata,
  output logic          tb_re,
  input  logic [31:0]   tb_rdata,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic [AW:0]   remaining;
  logic          cmd_fire;
  logic          load_fire;
  logic          slot_free;
  logic          rd_fire;

  // Explicit wrap keeps the walk modulo DEPTH even for non-power-of-two depths.
  assign addr_inc  = (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;

  assign cmd_ready = (state == S_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  // The memory drops our write when the CPU writes, so refuse data in that cycle.
  assign s_ready   = (state == S_LOAD) && !cpu_we;
  assign load_fire = s_valid && s_ready;
  assign slot_free = !m_valid || m_ready;
  assign rd_fire   = (state == S_DUMP) && slot_free && (remaining != '0);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Memory port drive: only meaningful on a write or read fire, zero otherwise.
  always_comb begin
    tb_we    = load_fire;
    tb_re    = rd_fire;
    tb_addr  = '0;
    tb_wdata = '0;
    if (load_fire || rd_fire) begin
      tb_addr = addr;
    end
    if (load_fire) begin
      tb_wdata = s_data;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            state_nx = S_DONE;
          end else if (cmd_op) begin
            state_nx = S_DUMP;
          end else begin
            state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (load_fire && (remaining == (AW+1)'(1))) begin
          state_nx = S_DONE;
        end
      end
      S_DUMP: begin
        if (m_valid && m_ready && m_last) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Address/count walk and the one-entry DUMP output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr      <= cmd_base;
        remaining <= cmd_len;
      end else if (load_fire || rd_fire) begin
        addr      <= addr_inc;
        remaining <= remaining - 1'b1;
      end
      if (rd_fire) begin
        m_data  <= tb_rdata;
        m_valid <= 1'b1;
        m_last  <= (remaining == (AW+1)'(1));
      end else if ((state == S_DUMP) && slot_free) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_tb_engine.sv
// tb/tb_dmem_tb_engine.sv - directed self-checking bench for dmem_tb_engine
module tb_dmem_tb_engine;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          m_last;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [31:0]   tb_wdata;
  logic          tb_re;
  logic [31:0]   tb_rdata;
  logic          busy;
  logic          done;

  logic          mem_init;
  logic [31:0]   mem [0:DEPTH-1];
  logic [31:0]   exp_q [0:7];

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  always #5 clk = ~clk;

  dmem_tb_engine #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .cpu_we    (cpu_we),
    .tb_we     (tb_we),
    .tb_addr   (tb_addr),
    .tb_wdata  (tb_wdata),
    .tb_re     (tb_re),
    .tb_rdata  (tb_rdata),
    .busy      (busy),
    .done      (done)
  );

  // Data memory model: CPU write wins, tb write dropped in that cycle, combinational read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h5500_0000 + i;
    end else if (cpu_we) begin
      mem[cpu_addr] <= cpu_wdata;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_wdata;
    end
  end
  assign tb_rdata = mem[tb_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input string tag, input logic [AW-1:0] base, input logic [AW:0] len,
                          input int n, input bit toggle, output int cycles);
    int idx;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = base; cmd_len = len;
    #1;
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    tick;
    cmd_valid = 1'b0;
    idx = 0;
    cycles = 0;
    while (idx < n && cycles < 60) begin
      m_ready = toggle ? (cycles % 3 == 0) : 1'b1;
      #1;
      if (cycles == 0) begin
        check({tag, "_first_mvalid"}, 32'(m_valid), 32'd0);
        check({tag, "_first_re"}, 32'(tb_re), 32'd1);
        check({tag, "_first_addr"}, 32'(tb_addr), 32'(base));
      end
      if (m_valid) begin
        check({tag, "_data"}, m_data, exp_q[idx]);
        check({tag, "_last"}, 32'(m_last), 32'(idx == n - 1));
        if (m_ready) idx++;
      end
      tick;
      cycles++;
    end
    m_ready = 1'b0;
    check({tag, "_count"}, 32'(idx), 32'(n));
    #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_mvalid_off"}, 32'(m_valid), 32'd0);
    tick;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_init = 1'b1;
    tick; tick;
    mem_init = 1'b0;

    // Reset state
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_mlast", 32'(m_last), 32'd0);
    check("rst_mdata", m_data, 32'd0);
    check("rst_we_re", {30'd0, tb_we, tb_re}, 32'd0);
    check("rst_sready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    tick;

    // LOAD 4 words at base 10
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 10'd10; cmd_len = 11'd4;
    #1;
    check("ld4_cmd_ready", 32'(cmd_ready), 32'd1);
    tick;
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_data = 32'hA0 + k;
      #1;
      check("ld4_cmd_ready_busy", 32'(cmd_ready), 32'd0);
      check("ld4_we", 32'(tb_we), 32'd1);
      check("ld4_addr", 32'(tb_addr), 32'd10 + k);
      check("ld4_wdata", tb_wdata, 32'hA0 + k);
      tick;
    end
    s_valid = 1'b0;
    #1;
    check("ld4_done", 32'(done), 32'd1);
    check("ld4_busy_done", 32'(busy), 32'd1);
    check("ld4_we_off", 32'(tb_we), 32'd0);
    tick;
    check("ld4_done_once", 32'(done), 32'd0);
    check("ld4_idle_ready", 32'(cmd_ready), 32'd1);
    check("ld4_mem10", mem[10], 32'hA0);
    check("ld4_mem11", mem[11], 32'hA1);
    check("ld4_mem12", mem[12], 32'hA2);
    check("ld4_mem13", mem[13], 32'hA3);

    // LOAD 3 words at base 20, CPU write in the second data cycle
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 10'd20; cmd_len = 11'd3;
    tick;
    cmd_valid = 1'b0;
    s_valid = 1'b1; s_data = 32'hB0;
    #1;
    check("ld3_w0_addr", 32'(tb_addr), 32'd20);
    tick;
    s_data = 32'hB1; cpu_we = 1'b1; cpu_addr = 10'd100; cpu_wdata = 32'hC0DE;
    #1;
    check("ld3_stall_sready", 32'(s_ready), 32'd0);
    check("ld3_stall_we", 32'(tb_we), 32'd0);
    tick;
    cpu_we = 1'b0;
    #1;
    check("ld3_w1_we", 32'(tb_we), 32'd1);
    check("ld3_w1_addr", 32'(tb_addr), 32'd21);
    check("ld3_w1_data", tb_wdata, 32'hB1);
    tick;
    s_data = 32'hB2;
    #1;
    check("ld3_w2_addr", 32'(tb_addr), 32'd22);
    tick;
    s_valid = 1'b0;
    #1;
    check("ld3_done", 32'(done), 32'd1);
    tick;
    check("ld3_mem20", mem[20], 32'hB0);
    check("ld3_mem21", mem[21], 32'hB1);
    check("ld3_mem22", mem[22], 32'hB2);
    check("ld3_mem23", mem[23], 32'h5500_0017);
    check("ld3_cpu_mem", mem[100], 32'hC0DE);

    // DUMP 5 words at base 10 with m_ready toggling 1,0,0
    exp_q[0] = 32'hA0; exp_q[1] = 32'hA1; exp_q[2] = 32'hA2; exp_q[3] = 32'hA3;
    exp_q[4] = 32'h5500_000E;
    run_dump("dmp5", 10'd10, 11'd5, 5, 1'b1, cyc);

    // DUMP across the wrap point, m_ready held high
    exp_q[0] = 32'h5500_03FE; exp_q[1] = 32'h5500_03FF;
    exp_q[2] = 32'h5500_0000; exp_q[3] = 32'h5500_0001;
    run_dump("dmpwrap", 10'd1022, 11'd4, 4, 1'b0, cyc);
    check("dmpwrap_cycles", 32'(cyc), 32'd5);

    // Zero-length commands, both ops
    for (int op = 0; op < 2; op++) begin
      cmd_valid = 1'b1; cmd_op = op[0]; cmd_base = 10'd5; cmd_len = 11'd0;
      #1;
      check("len0_accept_we_re", {30'd0, tb_we, tb_re}, 32'd0);
      tick;
      cmd_valid = 1'b0;
      #1;
      check("len0_done", 32'(done), 32'd1);
      check("len0_we_re", {30'd0, tb_we, tb_re}, 32'd0);
      tick;
      check("len0_idle", 32'(cmd_ready), 32'd1);
      check("len0_done_off", 32'(done), 32'd0);
    end

    // Reset after 2 of 6 DUMP words
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 10'd10; cmd_len = 11'd6;
    tick;
    cmd_valid = 1'b0; m_ready = 1'b1;
    tick;
    check("rstmid_w0", m_data, 32'hA0);
    tick;
    check("rstmid_w1", m_data, 32'hA1);
    tick;
    rst_n = 1'b0;
    #1;
    check("rstmid_mvalid", 32'(m_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick;
    rst_n = 1'b1; m_ready = 1'b0;
    #1;
    check("rstmid_ready", 32'(cmd_ready), 32'd1);
    check("rstmid_mem", mem[11], 32'hA1);
    tick;
    exp_q[0] = 32'hB0; exp_q[1] = 32'hB1; exp_q[2] = 32'hB2;
    run_dump("dmp_after_rst", 10'd20, 11'd3, 3, 1'b1, cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
